t07_mmio_responder: RTL and testbench



---
 rtl/t07_mmio_responder.sv | 149 ++++++++++++++
 tb/tb_t07_mmio_responder.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t07_mmio_responder.sv
// t07_mmio_responder: MMIO request responder issuing one word access per rwi request
// Optional feature: define MMIO_TIMEOUT_EN to abort accesses that see no ack
// within TIMEOUT_CYCLES cycles (err_o set, reads/fetches return 32'hBAD0_BAD0).
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   rwi_i                request code: 00 idle, 10 read, 01 write, 11 fetch
//   addr_i, data_i       access address and write data, captured at launch
//   busy_o               high while an access is in flight
//   data_o, instr_o      last read data / last fetched instruction
//   err_o                last access timed out (0 when timeout is not built)
//   mem_req_o, mem_we_o  backing-port request and write enable
//   mem_addr_o           backing-port address
//   mem_wdata_o          backing-port write data
//   mem_rdata_i          backing-port read data, valid with ack
//   mem_ack_i            backing-port single-cycle completion
module t07_mmio_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  rwi_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic [31:0] data_o,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state, state_n;
    logic [1:0]  served, served_n;
    logic        busy_n, req_n, we_n;
    logic [31:0] data_n, instr_n, addr_n, wdata_n;
    logic        launch, done;
    logic [31:0] rd;

`ifdef MMIO_TIMEOUT_EN
    logic [31:0] cnt, cnt_n;
    logic        err_q, err_n;
    logic        tmo;

    // the last ACCESS cycle is the one where cnt reaches TIMEOUT_CYCLES-1
    assign tmo   = cnt == TIMEOUT_CYCLES - 1;
    assign done  = state == ACCESS && (mem_ack_i || tmo);
    assign rd    = mem_ack_i ? mem_rdata_i : 32'hBAD0_BAD0;
    assign err_o = err_q;
`else
    assign done  = state == ACCESS && mem_ack_i;
    assign rd    = mem_rdata_i;
    assign err_o = 1'b0;
`endif

    // HOLD only relaunches on a code different from the one just served, so a
    // handler that keeps rwi asserted past the busy edge does not re-trigger.
    assign launch = rwi_i != 2'b00 && (state == IDLE || (state == HOLD && rwi_i != served));

    always_comb begin
        state_n  = state;
        served_n = served;
        busy_n   = busy_o;
        req_n    = mem_req_o;
        we_n     = mem_we_o;
        data_n   = data_o;
        instr_n  = instr_o;
        addr_n   = mem_addr_o;
        wdata_n  = mem_wdata_o;
`ifdef MMIO_TIMEOUT_EN
        cnt_n    = cnt;
        err_n    = err_q;
`endif
        if (launch) begin
            state_n  = ACCESS;
            served_n = rwi_i;
            busy_n   = 1'b1;
            req_n    = 1'b1;
            we_n     = rwi_i == 2'b01;
            addr_n   = addr_i;
            wdata_n  = data_i;
`ifdef MMIO_TIMEOUT_EN
            cnt_n    = '0;
            err_n    = 1'b0;
`endif
        end else if (state == HOLD && rwi_i == 2'b00) begin
            state_n = IDLE;
        end else if (done) begin
            state_n = HOLD;
            busy_n  = 1'b0;
            req_n   = 1'b0;
            we_n    = 1'b0;
            data_n  = served == 2'b10 ? rd : data_o;
            instr_n = served == 2'b11 ? rd : instr_o;
`ifdef MMIO_TIMEOUT_EN
            err_n   = !mem_ack_i;
`endif
        end
`ifdef MMIO_TIMEOUT_EN
        else if (state == ACCESS) begin
            cnt_n = cnt + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            served      <= 2'b00;
            busy_o      <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            data_o      <= '0;
            instr_o     <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state       <= state_n;
            served      <= served_n;
            busy_o      <= busy_n;
            mem_req_o   <= req_n;
            mem_we_o    <= we_n;
            data_o      <= data_n;
            instr_o     <= instr_n;
            mem_addr_o  <= addr_n;
            mem_wdata_o <= wdata_n;
        end
    end

`ifdef MMIO_TIMEOUT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            err_q <= err_n;
        end
    end
`endif
endmodule

// File: tb/tb_t07_mmio_responder.sv
// tb_t07_mmio_responder: scoreboard bench for t07_mmio_responder
module tb_t07_mmio_responder;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [1:0]  rwi_i = 2'b00;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic        busy_o;
    logic [31:0] data_o;
    logic [31:0] instr_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] instr;
        int          hi;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_instr = '0;
    int          hi;
    int          we_cnt;
    logic        stable;
    logic [31:0] a0;
    logic [31:0] w0;

    t07_mmio_responder #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .nrst(nrst),
        .rwi_i(rwi_i),
        .addr_i(addr_i),
        .data_i(data_i),
        .busy_o(busy_o),
        .data_o(data_o),
        .instr_o(instr_o),
        .err_o(err_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // push the expected outcome of a request and advance the model
    task automatic push(input logic [1:0] code, input logic [31:0] rd, input int lat);
        if (code == 2'b10) m_data = rd;
        if (code == 2'b11) m_instr = rd;
        exp_q.push_back('{data: m_data, instr: m_instr, hi: lat});
    endtask

    function automatic exp_t pop();
        exp_t r;
        r = '{data: 32'hxxxx_xxxx, instr: 32'hxxxx_xxxx, hi: -1};
        if (exp_q.size() != 0) r = exp_q.pop_front();
        return r;
    endfunction

    // memory model: waits (bounded) for busy, acks in the lat-th access cycle
    // (lat 0 = never ack); returns at the negedge where busy is low again
    task automatic serve(input int lat, input logic [31:0] rd, output int n_hi,
                         output int n_we, output logic st, output logic [31:0] a,
                         output logic [31:0] w);
        int n;
        n = 0;
        n_hi = 0;
        n_we = 0;
        st = 1'b1;
        while (!busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        a = mem_addr_o;
        w = mem_wdata_o;
        while (busy_o && n_hi < 40) begin
            n_hi++;
            if (mem_we_o) n_we++;
            if (!mem_req_o || mem_addr_o !== a || mem_wdata_o !== w) st = 1'b0;
            if (n_hi == lat) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = rd;
            end
            @(negedge clk);
            mem_ack_i = 1'b0;
            mem_rdata_i = 32'h5A5A_5A5A;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, mem_req_o, mem_we_o, err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", {busy_o, mem_req_o, mem_we_o, err_o});
        end
        checks++;
        if (data_o !== 32'h0 || instr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data data=%h instr=%h want 0", data_o, instr_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem addr=%h wdata=%h want 0", mem_addr_o, mem_wdata_o);
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int req_seen;
        rwi_i = 2'b11;
        addr_i = 32'h3300_0000;
        push(2'b11, 32'h0000_0013, 3);
        serve(3, 32'h0000_0013, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || data_o !== e.data || instr_o !== e.instr) begin
            errors++;
            $display("FAIL fetch busy=%0d data=%h instr=%h want busy=%0d data=%h instr=%h",
                     hi, data_o, instr_o, e.hi, e.data, e.instr);
        end
        checks++;
        if (we_cnt !== 0) begin
            errors++;
            $display("FAIL fetch_we got %0d write cycles want 0", we_cnt);
        end
        checks++;
        if (a0 !== 32'h3300_0000 || stable !== 1'b1) begin
            errors++;
            $display("FAIL fetch_addr got %h stable=%b want 33000000 stable=1", a0, stable);
        end
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'h1111_1111;
            end
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_req_o || busy_o) req_seen++;
        end
        checks++;
        if (req_seen !== 0) begin
            errors++;
            $display("FAIL fetch_relaunch got %0d busy cycles while held want 0", req_seen);
        end
        checks++;
        if (instr_o !== m_instr || data_o !== m_data) begin
            errors++;
            $display("FAIL stray_ack instr=%h data=%h want %h %h", instr_o, data_o, m_instr, m_data);
        end
        rwi_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_read_then_fetch();
        rwi_i = 2'b10;
        addr_i = 32'h0000_0100;
        push(2'b10, 32'hDEAD_BEEF, 1);
        serve(1, 32'hDEAD_BEEF, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || data_o !== e.data || instr_o !== e.instr || a0 !== 32'h100) begin
            errors++;
            $display("FAIL read busy=%0d data=%h instr=%h addr=%h want busy=%0d data=%h instr=%h addr=100",
                     hi, data_o, instr_o, a0, e.hi, e.data, e.instr);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL read_hold busy=%b want 0", busy_o);
        end
        rwi_i = 2'b11;
        addr_i = 32'h0000_0104;
        push(2'b11, 32'h0040_0093, 2);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL nogap_launch busy=%b req=%b want 1 1", busy_o, mem_req_o);
        end
        serve(2, 32'h0040_0093, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || data_o !== e.data || instr_o !== e.instr || a0 !== 32'h104) begin
            errors++;
            $display("FAIL nogap_fetch busy=%0d data=%h instr=%h addr=%h want busy=%0d data=%h instr=%h addr=104",
                     hi, data_o, instr_o, a0, e.hi, e.data, e.instr);
        end
        rwi_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_write();
        rwi_i = 2'b01;
        addr_i = 32'h0000_0200;
        data_i = 32'h0000_00A5;
        push(2'b01, 32'hFFFF_FFFF, 3);
        serve(3, 32'hFFFF_FFFF, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || data_o !== e.data || instr_o !== e.instr) begin
            errors++;
            $display("FAIL write busy=%0d data=%h instr=%h want busy=%0d data=%h instr=%h",
                     hi, data_o, instr_o, e.hi, e.data, e.instr);
        end
        checks++;
        if (we_cnt !== 3) begin
            errors++;
            $display("FAIL write_we got %0d write cycles want 3", we_cnt);
        end
        checks++;
        if (a0 !== 32'h200 || w0 !== 32'hA5 || stable !== 1'b1) begin
            errors++;
            $display("FAIL write_bus addr=%h wdata=%h stable=%b want 200 a5 1", a0, w0, stable);
        end
        checks++;
        if (mem_we_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL write_after we=%b req=%b want 0 0", mem_we_o, mem_req_o);
        end
        data_i = '0;
        rwi_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_idle_gap();
        rwi_i = 2'b11;
        addr_i = 32'h0000_0300;
        push(2'b11, 32'h0000_0A01, 2);
        serve(2, 32'h0000_0A01, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || instr_o !== e.instr || data_o !== e.data) begin
            errors++;
            $display("FAIL gap_first busy=%0d instr=%h data=%h want %0d %h %h", hi, instr_o, data_o, e.hi, e.instr, e.data);
        end
        rwi_i = 2'b00;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle busy=%b want 0", busy_o);
        end
        rwi_i = 2'b11;
        push(2'b11, 32'h0000_0A02, 1);
        serve(1, 32'h0000_0A02, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || instr_o !== e.instr || data_o !== e.data) begin
            errors++;
            $display("FAIL gap_second busy=%0d instr=%h data=%h want %0d %h %h", hi, instr_o, data_o, e.hi, e.instr, e.data);
        end
        rwi_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        rwi_i = 2'b11;
        addr_i = 32'h0000_0500;
        push(2'b11, 32'h0000_0093, 2);
        @(negedge clk);
        rwi_i = 2'b10;
        addr_i = 32'h0000_0600;
        serve(2, 32'h0000_0093, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || instr_o !== e.instr || data_o !== e.data) begin
            errors++;
            $display("FAIL b2b_fetch busy=%0d instr=%h data=%h want %0d %h %h", hi, instr_o, data_o, e.hi, e.instr, e.data);
        end
        checks++;
        if (a0 !== 32'h500 || stable !== 1'b1) begin
            errors++;
            $display("FAIL b2b_addr got %h stable=%b want 500 1", a0, stable);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap busy=%b want 0", busy_o);
        end
        push(2'b10, 32'hCAFE_F00D, 1);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || mem_addr_o !== 32'h600) begin
            errors++;
            $display("FAIL b2b_launch busy=%b addr=%h want 1 600", busy_o, mem_addr_o);
        end
        serve(1, 32'hCAFE_F00D, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || instr_o !== e.instr || data_o !== e.data) begin
            errors++;
            $display("FAIL b2b_read busy=%0d instr=%h data=%h want %0d %h %h", hi, instr_o, data_o, e.hi, e.instr, e.data);
        end
        rwi_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rwi_i = 2'b11;
        addr_i = 32'h0000_0400;
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || instr_o !== 32'h0 || data_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_async busy=%b req=%b instr=%h data=%h want 0 0 0 0", busy_o, mem_req_o, instr_o, data_o);
        end
        m_data = '0;
        m_instr = '0;
        @(negedge clk);
        nrst = 1'b1;
        push(2'b11, 32'h0000_0077, 1);
        serve(1, 32'h0000_0077, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || instr_o !== e.instr || data_o !== e.data || a0 !== 32'h400) begin
            errors++;
            $display("FAIL rst_relaunch busy=%0d instr=%h data=%h addr=%h want %0d %h %h 400",
                     hi, instr_o, data_o, a0, e.hi, e.instr, e.data);
        end
        rwi_i = 2'b00;
        @(negedge clk);
    endtask

`ifdef MMIO_TIMEOUT_EN
    task automatic test_timeout();
        rwi_i = 2'b10;
        addr_i = 32'h0000_0700;
        push(2'b10, 32'hBAD0_BAD0, 4);
        serve(0, 32'h0, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || data_o !== e.data || err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout busy=%0d data=%h err=%b want %0d %h 1", hi, data_o, err_o, e.hi, e.data);
        end
        rwi_i = 2'b00;
        @(negedge clk);
        rwi_i = 2'b11;
        push(2'b11, 32'h0000_0001, 1);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear busy=%b err=%b want 1 0", busy_o, err_o);
        end
        serve(1, 32'h0000_0001, hi, we_cnt, stable, a0, w0);
        e = pop();
        checks++;
        if (hi !== e.hi || instr_o !== e.instr || err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next busy=%0d instr=%h err=%b want %0d %h 0", hi, instr_o, err_o, e.hi, e.instr);
        end
        rwi_i = 2'b00;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_read_then_fetch();
        test_write();
        test_idle_gap();
        test_back_to_back();
        test_reset_mid();
`ifdef MMIO_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
